// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
//
// Turns the Set-2 scan-code byte stream from the PS/2 receiver into ASCII
// characters and queues them for the LCD writer.
//
// A small FSM follows make / break (F0) / extended (E0) prefixes and tracks the
// Shift and Caps Lock state. A mapped make code produces a registered
// character and push flag. That pair is written into a power-of-two FIFO one
// cycle later. The FIFO is drained over a valid/ready handshake.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   ps2_code     in   [7:0] received scan-code byte
//   ps2_code_new in   one-cycle strobe, one per received byte
//   char_data    out  [7:0] ASCII at FIFO head (0x00 when empty)
//   char_valid   out  FIFO non-empty
//   char_ready   in   consumer takes the head when char_valid & char_ready
//   caps_lock    out  Caps Lock state
//   overflow     out  sticky: a character was dropped on a full FIFO
// -----------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_code,
  input  logic       ps2_code_new,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_t;

  // Returns {mapped, ascii} for a make code under the given modifier state.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic       shift,
                                           input logic       caps);
    logic       hit;
    logic       letter;
    logic [7:0] ch;
    hit    = 1'b1;
    letter = 1'b0;
    ch     = 8'h00;
    case (code)
      8'h1C: begin letter = 1'b1; ch = 8'h61; end  // a
      8'h32: begin letter = 1'b1; ch = 8'h62; end  // b
      8'h21: begin letter = 1'b1; ch = 8'h63; end  // c
      8'h23: begin letter = 1'b1; ch = 8'h64; end  // d
      8'h24: begin letter = 1'b1; ch = 8'h65; end  // e
      8'h2B: begin letter = 1'b1; ch = 8'h66; end  // f
      8'h34: begin letter = 1'b1; ch = 8'h67; end  // g
      8'h33: begin letter = 1'b1; ch = 8'h68; end  // h
      8'h43: begin letter = 1'b1; ch = 8'h69; end  // i
      8'h3B: begin letter = 1'b1; ch = 8'h6A; end  // j
      8'h42: begin letter = 1'b1; ch = 8'h6B; end  // k
      8'h4B: begin letter = 1'b1; ch = 8'h6C; end  // l
      8'h3A: begin letter = 1'b1; ch = 8'h6D; end  // m
      8'h31: begin letter = 1'b1; ch = 8'h6E; end  // n
      8'h44: begin letter = 1'b1; ch = 8'h6F; end  // o
      8'h4D: begin letter = 1'b1; ch = 8'h70; end  // p
      8'h15: begin letter = 1'b1; ch = 8'h71; end  // q
      8'h2D: begin letter = 1'b1; ch = 8'h72; end  // r
      8'h1B: begin letter = 1'b1; ch = 8'h73; end  // s
      8'h2C: begin letter = 1'b1; ch = 8'h74; end  // t
      8'h3C: begin letter = 1'b1; ch = 8'h75; end  // u
      8'h2A: begin letter = 1'b1; ch = 8'h76; end  // v
      8'h1D: begin letter = 1'b1; ch = 8'h77; end  // w
      8'h22: begin letter = 1'b1; ch = 8'h78; end  // x
      8'h35: begin letter = 1'b1; ch = 8'h79; end  // y
      8'h1A: begin letter = 1'b1; ch = 8'h7A; end  // z
      // Digit row: Shift selects the US symbol, Caps Lock is ignored.
      8'h45: ch = shift ? 8'h29 : 8'h30;
      8'h16: ch = shift ? 8'h21 : 8'h31;
      8'h1E: ch = shift ? 8'h40 : 8'h32;
      8'h26: ch = shift ? 8'h23 : 8'h33;
      8'h25: ch = shift ? 8'h24 : 8'h34;
      8'h2E: ch = shift ? 8'h25 : 8'h35;
      8'h36: ch = shift ? 8'h5E : 8'h36;
      8'h3D: ch = shift ? 8'h26 : 8'h37;
      8'h3E: ch = shift ? 8'h2A : 8'h38;
      8'h46: ch = shift ? 8'h28 : 8'h39;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: hit = 1'b0;
    endcase
    // Shift and Caps Lock cancel each other for letters.
    if (letter && (shift ^ caps)) ch = ch - 8'h20;
    return {hit, ch};
  endfunction

  // ---------------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            caps_q, caps_d;
  logic            push_q, push_d;
  logic [7:0]      push_data_q, push_data_d;
  logic [TW-1:0]   to_cnt_q;
  logic            timeout_hit;
  logic [8:0]      xlat;

  assign xlat        = translate(ps2_code, lshift_q | rshift_q, caps_q);
  assign timeout_hit = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      if (ps2_code_new || state_q == S_IDLE || timeout_hit) to_cnt_q <= '0;
      else                                                  to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    push_d      = 1'b0;
    push_data_d = xlat[7:0];
    if (ps2_code_new) begin
      case (state_q)
        S_IDLE: begin
          case (ps2_code)
            8'hF0:   state_d  = S_BREAK;
            8'hE0:   state_d  = S_EXT;
            8'h12:   lshift_d = 1'b1;
            8'h59:   rshift_d = 1'b1;
            8'h58:   caps_d   = ~caps_q;
            default: push_d   = xlat[8];
          endcase
        end
        S_BREAK: begin
          if (ps2_code == 8'h12) lshift_d = 1'b0;
          if (ps2_code == 8'h59) rshift_d = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = S_IDLE;
          case (ps2_code)
            8'hF0: state_d = S_EXT_BREAK;
            8'h5A: begin push_d = 1'b1; push_data_d = 8'h0D; end  // keypad Enter
            8'h4A: begin push_d = 1'b1; push_data_d = 8'h2F; end  // keypad '/'
            default: ;
          endcase
        end
        S_EXT_BREAK: state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      // A stalled prefix is abandoned so the next byte is taken as a fresh code.
      state_d = S_IDLE;
    end
  end

  assign caps_lock = caps_q;

  // ---------------------------------------------------------------------------
  // Character FIFO: extra pointer MSB distinguishes full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && char_ready;
  // A simultaneous pop frees the head slot, so a push onto a full FIFO still fits.
  assign push_ok    = push_q && (!fifo_full || pop);

  // NOTE: the storage array has no reset; its contents are never observed
  // until written, because char_data is forced to 0x00 while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_q && !push_ok) overflow <= 1'b1;
    end
  end

  assign char_valid = !fifo_empty;
  assign char_data  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Scoreboard bench: each key strobe that should yield a character pushes the
// expected ASCII into a queue; a monitor pops and compares on every handshake.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. TIMEOUT_CYCLES is shortened so the stall case runs quickly.
// -----------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_code = 8'h00;
  logic       ps2_code_new = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       caps_lock;
  logic       overflow;

  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         n_pops = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_c;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_code     (ps2_code),
    .ps2_code_new (ps2_code_new),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .caps_lock    (caps_lock),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake monitor: a pop happens at the next rising edge with these values.
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("spurious_char_valid", {7'd0, char_valid}, 8'h00);
      end else begin
        exp_c = sb.pop_front();
        check("char", char_data, exp_c);
      end
    end
  end

  task automatic strobe(input logic [7:0] code);
    @(posedge clk); #1;
    ps2_code     = code;
    ps2_code_new = 1'b1;
    @(posedge clk); #1;
    ps2_code_new = 1'b0;
  endtask

  task automatic key(input logic [7:0] code, input logic [7:0] exp);
    sb.push_back(exp);
    strobe(code);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    char_ready = r;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(tag, 8'(sb.size()), 8'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_char_valid", {7'd0, char_valid}, 8'h00);
    check("rst_char_data",  char_data,          8'h00);
    check("rst_caps_lock",  {7'd0, caps_lock},  8'h00);
    check("rst_overflow",   {7'd0, overflow},   8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Two-cycle latency: strobe at E0, char_valid only after E1.
    key(8'h1C, 8'h61);
    @(negedge clk);
    check("lat_valid_e0", {7'd0, char_valid}, 8'h00);
    @(negedge clk);
    check("lat_valid_e1", {7'd0, char_valid}, 8'h01);
    check("lat_data_e1",  char_data,          8'h61);
    set_ready(1'b1);
    drain("drain_basic");
    strobe(8'hF0); strobe(8'h1C);        // break code yields nothing
    drain("drain_break");

    // Shift press / release.
    strobe(8'h12); key(8'h1C, 8'h41);
    strobe(8'hF0); strobe(8'h12); key(8'h1C, 8'h61);
    // Right shift with digits, then plain digit and space/backspace.
    strobe(8'h59); key(8'h16, 8'h21); key(8'h1E, 8'h40);
    strobe(8'hF0); strobe(8'h59); key(8'h45, 8'h30);
    key(8'h29, 8'h20); key(8'h66, 8'h08);
    strobe(8'h0E);                       // unmapped, dropped
    drain("drain_shift");

    // Extended codes.
    strobe(8'hE0); key(8'h5A, 8'h0D);
    strobe(8'hE0); key(8'h4A, 8'h2F);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h5A);
    key(8'h1C, 8'h61);                   // FSM is back in IDLE
    drain("drain_ext");

    // Stalled E0 prefix times out; following 1C is an ordinary make code.
    strobe(8'hE0);
    repeat (TO + 5) @(posedge clk);
    key(8'h1C, 8'h61);
    drain("drain_timeout");

    // Back-to-back strobes on consecutive cycles.
    sb.push_back(8'h61); sb.push_back(8'h62); sb.push_back(8'h63);
    @(posedge clk); #1 ps2_code = 8'h1C; ps2_code_new = 1'b1;
    @(posedge clk); #1 ps2_code = 8'h32;
    @(posedge clk); #1 ps2_code = 8'h21;
    @(posedge clk); #1 ps2_code_new = 1'b0;
    drain("drain_burst");

    // Overflow: DEPTH+1 letters with the consumer stalled.
    set_ready(1'b0);
    key(8'h1C, 8'h61); key(8'h32, 8'h62); key(8'h21, 8'h63); key(8'h23, 8'h64);
    strobe(8'h24);                       // dropped
    repeat (3) @(negedge clk);
    check("ovf_flag",      {7'd0, overflow},   8'h01);
    check("ovf_valid",     {7'd0, char_valid}, 8'h01);
    check("ovf_head_held", char_data,          8'h61);
    p0 = n_pops;
    set_ready(1'b1);
    drain("drain_ovf");
    check("ovf_pop_count", 8'(n_pops - p0), 8'd4);
    check("ovf_empty",     {7'd0, char_valid}, 8'h00);
    check("ovf_sticky",    {7'd0, overflow},   8'h01);

    // Caps Lock toggles on make only; Shift cancels it for letters.
    strobe(8'h58); strobe(8'hF0); strobe(8'h58);
    @(negedge clk);
    check("caps_on", {7'd0, caps_lock}, 8'h01);
    key(8'h1C, 8'h41);
    key(8'h16, 8'h31);                   // digits ignore Caps Lock
    strobe(8'h12); key(8'h1C, 8'h61);
    drain("drain_caps");

    // Reset mid-sequence with a buffered character and Shift held.
    set_ready(1'b0);
    strobe(8'h1C);                       // buffered, discarded by reset
    strobe(8'h12); strobe(8'hF0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_caps",     {7'd0, caps_lock},  8'h00);
    check("rst2_valid",    {7'd0, char_valid}, 8'h00);
    check("rst2_overflow", {7'd0, overflow},   8'h00);
    set_ready(1'b1);
    key(8'h1C, 8'h61);                   // shift cleared, not in BREAK
    drain("drain_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
